melody_player: RTL and testbench
================================

Name: melody_player

Overview:
Parametrised successor to the car's single-tune buzzer driver.
- Plays an arbitrary song from a writable note RAM. Each entry holds a tone half-period (in clocks) and a duration in beats.
- Adds runtime start, stop and loop control, rest notes, an articulation gap between notes, mute, and busy/done status.
- Sits between the car controller (which loads songs and triggers playback) and the speaker pin.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- TICK_HZ, 5, beat rate. TICK_CYC = CLK_HZ/TICK_HZ clocks per beat.
- GAP_CYCLES, 500_000, silent clocks after every note; must be < TICK_CYC.
- PERIOD_W, 20, width of the half-period field.
- DUR_W, 4, width of the beat-count field.
- LEN_W, 8, note RAM address width (depth 2^LEN_W).

Ports:
- clk_50M  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- wr_en  in  1  note RAM write strobe.
- wr_addr  in  LEN_W  note RAM write address.
- wr_data  in  PERIOD_W+DUR_W  {half_period, dur}; half_period 0 = rest.
- start  in  1  one-cycle pulse, begin playback at index 0.
- stop  in  1  one-cycle pulse, abort playback.
- loop_en  in  1  restart from index 0 after the last note.
- song_len  in  LEN_W  index of the last note; sampled on start.
- mute  in  1  force speaker low without pausing the sequence.
- speaker  out  1  square-wave output.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse on natural song completion.
- cur_idx  out  LEN_W  index of the note being fetched or played.

Behaviour:
- Reset (rst low at a clk_50M edge):
  - FSM to IDLE; speaker=0, busy=0, done=0, cur_idx=0.
  - All counters cleared. Note RAM contents are not reset.
  - Applies mid-song too; outputs are low from the next cycle.
- FSM states: IDLE, FETCH, LATCH, PLAY, GAP.
- IDLE:
  - start=1 and stop=0 -> FETCH; song_len latched; cur_idx=0.
  - start is ignored in every other state.
- FETCH: RAM read address = cur_idx (synchronous read, 1-cycle latency) -> LATCH.
- LATCH:
  - Capture half_period and dur into note registers. A dur of 0 is treated as 1.
  - Clear the tone counter, the beat prescaler and the beat counter; speaker=0 -> PLAY.
- PLAY, beat timing:
  - Prescaler counts 0..TICK_CYC-1 and emits a tick at TICK_CYC-1.
  - Beat counter increments on each tick; reaching dur -> GAP.
  - Note audible time is exactly dur*TICK_CYC clocks.
- PLAY, tone generation:
  - Tone counter counts 0..half_period-1; at half_period-1 it wraps and toggles the internal tone bit.
  - The first rising edge of speaker is half_period cycles after PLAY entry.
  - half_period=1 toggles every cycle.
  - half_period=0 holds the tone bit low (rest).
- GAP:
  - Tone bit low for GAP_CYCLES clocks.
  - At the end, if cur_idx != latched song_len: cur_idx+1 -> FETCH.
  - If cur_idx == song_len and loop_en=1 (sampled at that cycle): cur_idx=0 -> FETCH.
  - Otherwise: done=1 for one cycle, busy=0 in that same cycle -> IDLE.
- Note period: total clocks per note = 2 + dur*TICK_CYC + GAP_CYCLES.
- cur_idx wraps naturally at 2^LEN_W-1 -> 0 only when song_len is the maximum index.
- speaker = tone bit AND NOT mute, registered, so mute takes effect 1 cycle after it changes.
- stop:
  - In any non-IDLE state -> IDLE next cycle, speaker=0, busy=0, no done pulse.
  - stop and start in the same cycle in IDLE: stop wins, remain IDLE.
- RAM writes:
  - Accepted in any state.
  - A write to the currently playing index affects only a later fetch.
  - A write and a read to the same address in the same cycle: the read returns the old data.
- Width rules: all counters are unsigned. The prescaler width is clog2(TICK_CYC) and the gap counter width is clog2(GAP_CYCLES+1).

Decomposition:
- Package melody_pkg holds:
  - state enum (IDLE/FETCH/LATCH/PLAY/GAP);
  - NOTE_W = PERIOD_W+DUR_W;
  - field slice positions;
  - REST_PERIOD = 0;
  - TICK_CYC derivation.
- Sub-module note_ram: simple dual-port synchronous RAM (1 write port, 1 registered read port), 2^LEN_W x NOTE_W, no reset.

Test Plan (sim params: CLK_HZ=1000, TICK_HZ=10 so TICK_CYC=100, GAP_CYCLES=5, LEN_W=4):
1. Reset: hold rst=0 for 3 cycles with start=1 -> speaker=0, busy=0, done=0, cur_idx=0 throughout; after release, stays IDLE without a new start.
2. Single note: RAM[0]={3,2}, song_len=0, start -> busy high next cycle; speaker first rises 3 cycles after PLAY entry and toggles every 3 cycles for 200 cycles; then low 5 cycles; done pulses once with busy falling that cycle. Total 207 cycles from FETCH entry.
3. Rest and dur=0: RAM[0]={0,0}, RAM[1]={2,1}, song_len=1 -> speaker low for 100+5 cycles, cur_idx moves 0->1, then a 2-cycle half-period tone for 100 cycles; a single done pulse.
4. Loop: 3 notes, loop_en=1 -> cur_idx sequence 0,1,2,0,1 with no done; clear loop_en during note 1 -> done after index 2 of that pass.
5. Stop and mute: mute=1 during PLAY -> speaker low one cycle later while cur_idx still advances on schedule; stop mid-note -> busy=0 and speaker=0 next cycle, no done; start+stop in the same cycle in IDLE -> busy stays 0.
6. Reset mid-song and RAM retention: rst=0 during note 1 -> IDLE with all outputs low; start again -> the same RAM contents play from index 0 with identical timing to the first run.

Source files
------------

// File: rtl/melody_pkg.sv
// melody_pkg: shared types and constants for the melody player.
//   state_t       - sequencer states
//   NOTE_W        - default note word width (half_period + dur)
//   DUR_LSB       - bit position of the beat-count field in a note word
//   period_lsb()  - bit position of the half-period field for a given DUR_W
//   REST_PERIOD   - half-period value that denotes a silent note
//   tick_cyc()    - clocks per beat from clock and beat rates
package melody_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_GAP
  } state_t;

  localparam int DEF_PERIOD_W = 20;
  localparam int DEF_DUR_W    = 4;
  localparam int NOTE_W       = DEF_PERIOD_W + DEF_DUR_W;

  // Note word layout: {half_period, dur}, dur in the low bits.
  localparam int DUR_LSB     = 0;
  localparam int REST_PERIOD = 0;

  function automatic int period_lsb(input int dur_w);
    return dur_w;
  endfunction

  function automatic int tick_cyc(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/melody_player_ram.sv
// note_ram: simple dual-port synchronous RAM holding the song.
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - note word written
//   rd_addr  - read address (always read, one-cycle latency)
//   rd_data  - registered read data; same-address write returns old data
// No reset: contents survive a player reset.
module note_ram
  import melody_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int WORD_W = NOTE_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LEN_W-1:0]  wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [2**LEN_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/melody_player.sv
// melody_player: plays a song stored in a writable note RAM on a speaker pin.
//   clk_50M  - system clock
//   rst      - synchronous active-low reset
//   wr_en/wr_addr/wr_data - note RAM write port, wr_data = {half_period, dur}
//   start/stop - one-cycle playback control pulses
//   loop_en  - restart at index 0 after the last note
//   song_len - index of the last note, sampled on start
//   mute     - gate the speaker without pausing the sequence
//   speaker  - square-wave output
//   busy/done - status; done pulses on natural completion
//   cur_idx  - index of the note being fetched or played
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start
// S_FETCH | RAM read of cur_idx in flight
// S_LATCH | read data valid, load note registers
// S_PLAY  | tone output for dur beats
// S_GAP   | silent articulation gap, then next note / end
module melody_player
  import melody_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 5,
  parameter int GAP_CYCLES = 500_000,
  parameter int PERIOD_W   = 20,
  parameter int DUR_W      = 4,
  parameter int LEN_W      = 8
) (
  input  logic                      clk_50M,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [LEN_W-1:0]          wr_addr,
  input  logic [PERIOD_W+DUR_W-1:0] wr_data,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [LEN_W-1:0]          song_len,
  input  logic                      mute,
  output logic                      speaker,
  output logic                      busy,
  output logic                      done,
  output logic [LEN_W-1:0]          cur_idx
);

  localparam int NW       = PERIOD_W + DUR_W;
  localparam int TICK_CYC = tick_cyc(CLK_HZ, TICK_HZ);
  localparam int PS_W     = $clog2(TICK_CYC);
  localparam int GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam int P_LSB    = period_lsb(DUR_W);

  state_t              state;
  logic [LEN_W-1:0]    song_len_q;
  logic [PERIOD_W-1:0] hp_q;
  logic [DUR_W-1:0]    dur_q;
  logic [PERIOD_W-1:0] tone_cnt;
  logic [PS_W-1:0]     presc;
  logic [DUR_W-1:0]    beat_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic                tone;
  logic [NW-1:0]       rd_data;

  logic [PERIOD_W-1:0] rd_hp;
  logic [DUR_W-1:0]    rd_dur;
  logic                tick;
  logic                play_end;
  logic                tone_wrap;
  logic                tone_nxt;

  note_ram #(.LEN_W(LEN_W), .WORD_W(NW)) u_ram (
    .clk     (clk_50M),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (cur_idx),
    .rd_data (rd_data)
  );

  assign rd_hp  = rd_data[P_LSB +: PERIOD_W];
  assign rd_dur = rd_data[DUR_LSB +: DUR_W];

  assign tick      = (presc == PS_W'(TICK_CYC - 1));
  assign play_end  = (state == S_PLAY) && tick && ((beat_cnt + DUR_W'(1)) == dur_q);
  assign tone_wrap = (tone_cnt == hp_q - PERIOD_W'(1));

  // Next tone bit; speaker registers this same value so a tone edge and
  // the speaker edge land in the same cycle, while mute lags by one clock.
  always_comb begin
    tone_nxt = 1'b0;
    if (state == S_PLAY && !play_end && hp_q != PERIOD_W'(REST_PERIOD))
      tone_nxt = tone_wrap ? ~tone : tone;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst) begin
      state      <= S_IDLE;
      song_len_q <= '0;
      hp_q       <= '0;
      dur_q      <= '0;
      tone_cnt   <= '0;
      presc      <= '0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      tone       <= 1'b0;
      speaker    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cur_idx    <= '0;
    end else begin
      done    <= 1'b0;
      tone    <= tone_nxt;
      speaker <= tone_nxt & ~mute;
      if (stop && state != S_IDLE) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        tone    <= 1'b0;
        speaker <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              state      <= S_FETCH;
              busy       <= 1'b1;
              cur_idx    <= '0;
              song_len_q <= song_len;
            end
          end
          S_FETCH: state <= S_LATCH;
          S_LATCH: begin
            hp_q     <= rd_hp;
            dur_q    <= (rd_dur == DUR_W'(0)) ? DUR_W'(1) : rd_dur;
            tone_cnt <= '0;
            presc    <= '0;
            beat_cnt <= '0;
            state    <= S_PLAY;
          end
          S_PLAY: begin
            tone_cnt <= tone_wrap ? '0 : tone_cnt + PERIOD_W'(1);
            presc    <= tick ? '0 : presc + PS_W'(1);
            if (tick) beat_cnt <= beat_cnt + DUR_W'(1);
            if (play_end) begin
              state   <= S_GAP;
              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end
          end
          S_GAP: begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end else if (cur_idx != song_len_q) begin
              cur_idx <= cur_idx + LEN_W'(1);
              state   <= S_FETCH;
            end else if (loop_en) begin
              cur_idx <= '0;
              state   <= S_FETCH;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_player.sv
module tb_melody_player;

  localparam int PW = 20;
  localparam int DW = 4;
  localparam int LW = 4;

  logic          clk_50M = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [LW-1:0] wr_addr = '0;
  logic [PW+DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [LW-1:0] song_len = '0;
  logic          mute = 1'b0;
  logic          speaker;
  logic          busy;
  logic          done;
  logic [LW-1:0] cur_idx;

  int checks = 0;
  int errors = 0;

  melody_player #(
    .CLK_HZ(1000), .TICK_HZ(10), .GAP_CYCLES(5),
    .PERIOD_W(PW), .DUR_W(DW), .LEN_W(LW)
  ) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .stop    (stop),
    .loop_en (loop_en),
    .song_len(song_len),
    .mute    (mute),
    .speaker (speaker),
    .busy    (busy),
    .done    (done),
    .cur_idx (cur_idx)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic wr_note(input int addr, input int hp, input int dur);
    wr_en   = 1'b1;
    wr_addr = LW'(addr);
    wr_data = {PW'(hp), DW'(dur)};
    nclk(1);
    wr_en   = 1'b0;
  endtask

  // Pulses start, then observes until done. Cycle 0 is the FETCH cycle.
  task automatic run_song(input int budget, output int busy0, output int done_at,
                          output int first_rise, output int rises, output int idx1_at);
    int prev;
    start = 1'b1;
    nclk(1);
    start = 1'b0;
    busy0 = int'(busy);
    done_at = -1; first_rise = -1; rises = 0; idx1_at = -1; prev = 0;
    for (int n = 0; n < budget; n++) begin
      if (speaker && prev == 0) begin
        rises++;
        if (first_rise < 0) first_rise = n;
      end
      prev = int'(speaker);
      if (idx1_at < 0 && cur_idx == LW'(1)) idx1_at = n;
      if (done) begin
        done_at = n;
        break;
      end
      nclk(1);
    end
  endtask

  typedef struct {
    int hp0, dur0, hp1, dur1, len;
    int exp_done, exp_first, exp_rises, exp_idx1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int b0, d_at, fr, rs, i1, n_done, prev_idx, done_at;
    int seq[$];
    int exp_seq[6];

    // Reset held with start asserted
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nclk(1);
      chk("reset_outputs", {speaker, busy, done, cur_idx}, 0);
    end
    rst = 1'b1;
    start = 1'b0;
    nclk(5);
    chk("idle_after_reset", {busy, done, cur_idx}, 0);

    // Single and two-note songs: {hp0,dur0,hp1,dur1,len, done, first rise, rises, idx->1}
    vecs[0] = '{3, 2, 0, 0, 0, 207,   5, 33,  -1};
    vecs[1] = '{1, 1, 0, 0, 0, 107,   3, 50,  -1};
    vecs[2] = '{5, 0, 0, 0, 0, 107,   7, 10,  -1};
    vecs[3] = '{0, 0, 2, 1, 1, 214, 111, 25, 107};
    vecs[4] = '{0, 1, 0, 1, 1, 214,  -1,  0, 107};
    loop_en = 1'b0;
    for (int v = 0; v < 5; v++) begin
      wr_note(0, vecs[v].hp0, vecs[v].dur0);
      wr_note(1, vecs[v].hp1, vecs[v].dur1);
      song_len = LW'(vecs[v].len);
      run_song(1000, b0, d_at, fr, rs, i1);
      chk($sformatf("v%0d_busy_start", v), b0, 1);
      chk($sformatf("v%0d_done_at", v), d_at, vecs[v].exp_done);
      chk($sformatf("v%0d_busy_at_done", v), busy, 0);
      chk($sformatf("v%0d_first_rise", v), fr, vecs[v].exp_first);
      chk($sformatf("v%0d_rises", v), rs, vecs[v].exp_rises);
      chk($sformatf("v%0d_idx1_at", v), i1, vecs[v].exp_idx1);
      nclk(1);
      chk($sformatf("v%0d_done_one_cycle", v), done, 0);
    end

    // Loop: 0,1,2,0,1 then loop_en dropped during the second index 1
    wr_note(0, 1, 1);
    wr_note(1, 2, 1);
    wr_note(2, 3, 1);
    song_len = LW'(2);
    loop_en = 1'b1;
    start = 1'b1;
    nclk(1);
    start = 1'b0;
    done_at = -1;
    prev_idx = -1;
    for (int n = 0; n < 1000; n++) begin
      if (int'(cur_idx) != prev_idx) begin
        seq.push_back(int'(cur_idx));
        prev_idx = int'(cur_idx);
      end
      if (done) begin
        done_at = n;
        break;
      end
      if (n == 450) loop_en = 1'b0;
      nclk(1);
    end
    exp_seq = '{0, 1, 2, 0, 1, 2};
    chk("loop_done_at", done_at, 642);
    chk("loop_seq_len", seq.size(), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++)
      chk($sformatf("loop_seq_%0d", i), seq[i], exp_seq[i]);
    nclk(1);

    // Mute and stop
    wr_note(0, 3, 1);
    wr_note(1, 3, 1);
    song_len = LW'(1);
    mute = 1'b0;
    start = 1'b1;
    nclk(1);
    start = 1'b0;
    nclk(5);
    chk("tone_high_unmuted", speaker, 1);
    mute = 1'b1;
    nclk(1);
    chk("mute_next_cycle", speaker, 0);
    nclk(100);
    chk("idx_before_step", cur_idx, 0);
    nclk(1);
    chk("idx_on_schedule_muted", cur_idx, 1);
    nclk(13);
    mute = 1'b0;
    nclk(28);
    chk("tone_high_before_stop", speaker, 1);
    stop = 1'b1;
    nclk(1);
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_speaker", speaker, 0);
    n_done = 0;
    for (int n = 0; n < 300; n++) begin
      if (done || busy) n_done++;
      nclk(1);
    end
    chk("stop_no_done", n_done, 0);
    start = 1'b1;
    stop = 1'b1;
    nclk(1);
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_idle", busy, 0);
    nclk(3);
    chk("start_stop_idle_later", busy, 0);

    // Reset mid-song, RAM retained, identical replay
    wr_note(0, 2, 1);
    wr_note(1, 4, 1);
    wr_note(2, 1, 1);
    song_len = LW'(2);
    loop_en = 1'b0;
    start = 1'b1;
    nclk(1);
    start = 1'b0;
    nclk(150);
    chk("pre_reset_idx", cur_idx, 1);
    rst = 1'b0;
    nclk(1);
    chk("mid_reset_outputs", {speaker, busy, done, cur_idx}, 0);
    rst = 1'b1;
    nclk(3);
    chk("post_reset_idle", busy, 0);
    run_song(1000, b0, d_at, fr, rs, i1);
    chk("replay_busy_start", b0, 1);
    chk("replay_done_at", d_at, 321);
    chk("replay_first_rise", fr, 4);
    chk("replay_rises", rs, 87);
    chk("replay_idx1_at", i1, 107);
    nclk(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
